// File: rtl/alm_pkg.sv
// Shared definitions for the approximate log multiplier datapath.
// Default widths, rounding modes and the log-domain word {k,f,zero}.
package alm_pkg;

  localparam int ALM_FRAC_W = 15;
  localparam int ALM_K_W    = 5;
  localparam int ALM_OUT_W  = 32;

  localparam int ROUND_TRUNC  = 0;
  localparam int ROUND_HALFUP = 1;

  typedef struct packed {
    logic [ALM_K_W-1:0]    k;
    logic [ALM_FRAC_W-1:0] f;
    logic                  zero;
  } alm_log_t;

endpackage

// File: rtl/alm_bshift.sv
// Combinational bidirectional logical barrel shifter.
// Ports: din (WIDTH), amt (SH_W), dir_left (1=left), dout (WIDTH).
module alm_bshift #(
  parameter int WIDTH = 49,
  parameter int SH_W  = 6
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SH_W-1:0]  amt,
  input  logic             dir_left,
  output logic [WIDTH-1:0] dout
);

  assign dout = dir_left ? (din << amt) : (din >> amt);

endmodule

// File: rtl/alm_antilog_pipe.sv
// Antilog converter: {k,f} -> y ~= (1+f/2^FRAC_W)*2^k, 3-stage pipe.
// Ports: clk, rst (sync, high), in_valid/in_ready/in_k/in_f/in_zero,
//        out_valid/out_ready/out_y/out_ovf (saturate when k >= OUT_W).
module alm_antilog_pipe
  import alm_pkg::*;
#(
  parameter int FRAC_W = ALM_FRAC_W,
  parameter int K_W    = ALM_K_W,
  parameter int OUT_W  = ALM_OUT_W,
  parameter int ROUND  = ROUND_TRUNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_W-1:0]    in_k,
  input  logic [FRAC_W-1:0] in_f,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              out_ovf
);

  localparam int AMT_W = K_W + 1;
  localparam int M_W   = FRAC_W + 1;
  // One guard bit below the mantissa catches the rounding bit.
  localparam int SW    = OUT_W + FRAC_W + 2;

  logic adv;

  // Stage 1 state
  logic             s1_vld_q;
  logic [M_W-1:0]   s1_m_q;
  logic             s1_zero_q;
  logic             s1_ovf_q;
  logic             s1_dir_q;
  logic [AMT_W-1:0] s1_amt_q;

  logic [AMT_W-1:0] kx;
  logic [AMT_W-1:0] fw;
  logic             s1_dir_d;
  logic [AMT_W-1:0] s1_amt_d;
  logic             s1_ovf_d;

  // Stage 2 state
  logic             s2_vld_q;
  logic [SW-1:0]    s2_data_q;
  logic             s2_zero_q;
  logic             s2_ovf_q;
  logic             s2_dir_q;
  logic [2:0]       s2_fine_q;

  logic [SW-1:0]    s2_din;
  logic [AMT_W-1:0] s2_camt;
  logic [SW-1:0]    s2_data_d;

  // Stage 3 / output state
  logic             out_valid_q;
  logic [OUT_W-1:0] out_y_q;
  logic             out_ovf_q;

  logic [SW-1:0]    s3_sh;
  logic             s3_rbit;
  logic [OUT_W-1:0] s3_y;
  logic [OUT_W-1:0] out_y_d;
  logic             out_ovf_d;
  logic             unused_hi;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign kx       = AMT_W'(in_k);
  assign fw       = AMT_W'(FRAC_W);
  assign s1_dir_d = kx >= fw;
  assign s1_amt_d = s1_dir_d ? (kx - fw) : (fw - kx);
  assign s1_ovf_d = int'(in_k) >= OUT_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_m_q    <= '0;
      s1_zero_q <= 1'b0;
      s1_ovf_q  <= 1'b0;
      s1_dir_q  <= 1'b0;
      s1_amt_q  <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_m_q    <= {1'b1, in_f};
        s1_zero_q <= in_zero;
        s1_ovf_q  <= s1_ovf_d;
        s1_dir_q  <= s1_dir_d;
        s1_amt_q  <= s1_amt_d;
      end
    end
  end

  // Coarse shift covers the multiples of 8; the low 3 bits go to S3.
  assign s2_din  = {{OUT_W{1'b0}}, s1_m_q, 1'b0};
  assign s2_camt = {s1_amt_q[AMT_W-1:3], 3'b000};

  alm_bshift #(
    .WIDTH (SW),
    .SH_W  (AMT_W)
  ) u_coarse (
    .din      (s2_din),
    .amt      (s2_camt),
    .dir_left (s1_dir_q),
    .dout     (s2_data_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_zero_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
      s2_dir_q  <= 1'b0;
      s2_fine_q <= '0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q <= s2_data_d;
        s2_zero_q <= s1_zero_q;
        s2_ovf_q  <= s1_ovf_q;
        s2_dir_q  <= s1_dir_q;
        s2_fine_q <= s1_amt_q[2:0];
      end
    end
  end

  alm_bshift #(
    .WIDTH (SW),
    .SH_W  (3)
  ) u_fine (
    .din      (s2_data_q),
    .amt      (s2_fine_q),
    .dir_left (s2_dir_q),
    .dout     (s3_sh)
  );

  // After a right shift the guard bit holds the first bit shifted out.
  assign s3_rbit   = (ROUND == ROUND_HALFUP) && !s2_dir_q && s3_sh[0];
  assign s3_y      = s3_sh[OUT_W:1] + OUT_W'(s3_rbit);
  assign unused_hi = ^s3_sh[SW-1:OUT_W+1];

  always_comb begin
    out_y_d   = s3_y;
    out_ovf_d = 1'b0;
    if (s2_zero_q) begin
      out_y_d   = '0;
    end else if (s2_ovf_q) begin
      out_y_d   = '1;
      out_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_y_q   <= out_y_d;
        out_ovf_q <= out_ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_alm_antilog_pipe.sv
// Bench for alm_antilog_pipe: truncating and rounding instances in lockstep.
// Results are checked against an arithmetic reference of (2^15+f)*2^k/2^15.
module tb_alm_antilog_pipe;
  import alm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_k = '0;
  logic [14:0] in_f = '0;
  logic        in_zero = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic        out_ovf0, out_ovf1;
  logic [31:0] out_y0, out_y1;

  always #5 clk = ~clk;

  alm_antilog_pipe #(.ROUND(ROUND_TRUNC)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_k(in_k), .in_f(in_f), .in_zero(in_zero),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_y(out_y0), .out_ovf(out_ovf0)
  );

  alm_antilog_pipe #(.ROUND(ROUND_HALFUP)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_k(in_k), .in_f(in_f), .in_zero(in_zero),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_y(out_y1), .out_ovf(out_ovf1)
  );

  typedef struct {
    logic [31:0] y0;
    logic [31:0] y1;
    logic        ovf;
  } exp_t;

  int   n_run = 0;
  int   n_fail = 0;
  bit   acc, drn;
  exp_t q[$];

  function automatic alm_log_t mk(int k, int f, bit z);
    alm_log_t b;
    b.k = 5'(k);
    b.f = 15'(f);
    b.zero = z;
    return b;
  endfunction

  function automatic alm_log_t rnd_beat();
    return mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 32767)),
              $urandom_range(0, 15) == 0);
  endfunction

  function automatic exp_t model(alm_log_t b);
    exp_t   e;
    longint p;
    e.ovf = 1'b0;
    if (b.zero) begin
      e.y0 = '0;
      e.y1 = '0;
    end else if (int'(b.k) >= 32) begin
      e.y0 = '1;
      e.y1 = '1;
      e.ovf = 1'b1;
    end else begin
      p = longint'(32768 + int'(b.f)) <<< b.k;
      e.y0 = 32'(p >> 15);
      e.y1 = 32'((p + 64'sd16384) >> 15);
    end
    return e;
  endfunction

  task automatic step(input bit v, input alm_log_t b, input bit ordy);
    @(negedge clk);
    in_valid = v;
    in_k = b.k;
    in_f = b.f;
    in_zero = b.zero;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready0;
    drn = out_valid0 && out_ready;
    if (acc) q.push_back(model(b));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_run++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b/%b, expected 0", out_valid0, out_valid1);
    end
    n_run++;
    if (out_y0 !== 32'd0 || out_y1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_y: got %h/%h, expected 0", out_y0, out_y1);
    end
    n_run++;
    if (out_ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, expected 0", out_ovf0);
    end
    n_run++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b, expected 1", in_ready0, in_ready1);
    end
  endtask

  task automatic test_basic();
    alm_log_t    bs[2];
    logic [31:0] want[2];
    exp_t        e;
    int          lat;
    bs[0] = mk(0, 0, 0);
    bs[1] = mk(4, 'h4000, 0);
    want[0] = 32'd1;
    want[1] = 32'd24;
    foreach (bs[i]) begin
      step(1, bs[i], 1);
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
        step(0, mk(0, 0, 0), 1);
        if (drn) begin
          lat = c;
          e = q.pop_front();
          n_run++;
          if (out_y0 !== want[i] || out_y0 !== e.y0 ||
              out_y1 !== e.y1 || out_ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_y[%0d]: got %h/%h ovf %b, expected %h/%h ovf 0",
                     i, out_y0, out_y1, out_ovf0, want[i], e.y1);
          end
        end
      end
      n_run++;
      if (lat != 3) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d, expected 3", i, lat);
      end
    end
  endtask

  task automatic test_saturate();
    alm_log_t    bs[2];
    logic [31:0] want[2];
    exp_t        e;
    alm_log_t    cur;
    int          sent = 0;
    int          got = 0;
    bs[0] = mk(31, 'h7FFF, 0);
    bs[1] = mk(31, 'h7FFF, 1);
    want[0] = 32'hFFFF0000;
    want[1] = 32'h0;
    for (int c = 0; c < 20 && (sent < 2 || q.size() > 0); c++) begin
      cur = mk(0, 0, 0);
      if (sent < 2) cur = bs[sent];
      step(sent < 2, cur, 1);
      if (acc) sent++;
      if (drn && q.size() > 0) begin
        e = q.pop_front();
        n_run++;
        if (out_y0 !== want[got] || out_y1 !== e.y1 ||
            out_ovf0 !== 1'b0 || out_ovf1 !== 1'b0) begin
          n_fail++;
          $display("FAIL saturate[%0d]: got %h/%h ovf %b, expected %h/%h ovf 0",
                   got, out_y0, out_y1, out_ovf0, want[got], e.y1);
        end
        got++;
      end
    end
    n_run++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL saturate_count: got %0d results, expected 2", got);
    end
  endtask

  task automatic test_round();
    alm_log_t bs[2];
    exp_t     e;
    alm_log_t cur;
    int       sent = 0;
    int       got = 0;
    bs[0] = mk(0, 'h4000, 0);
    bs[1] = mk(3, 'h0FFF, 0);
    for (int c = 0; c < 20 && (sent < 2 || q.size() > 0); c++) begin
      cur = mk(0, 0, 0);
      if (sent < 2) cur = bs[sent];
      step(sent < 2, cur, 1);
      if (acc) sent++;
      if (drn && q.size() > 0) begin
        e = q.pop_front();
        n_run++;
        if (out_y0 !== e.y0 || out_y1 !== e.y1) begin
          n_fail++;
          $display("FAIL round[%0d]: got trunc %h round %h, expected %h %h",
                   got, out_y0, out_y1, e.y0, e.y1);
        end
        if (got == 0) begin
          n_run++;
          if (out_y0 !== 32'd1 || out_y1 !== 32'd2) begin
            n_fail++;
            $display("FAIL round_half: got %0d/%0d, expected 1/2", out_y0, out_y1);
          end
        end
        got++;
      end
    end
    n_run++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL round_count: got %0d results, expected 2", got);
    end
  endtask

  task automatic test_backpressure();
    alm_log_t    bs[6];
    exp_t        e;
    alm_log_t    cur;
    logic [31:0] held = '0;
    bit          ordy;
    int          sent = 0;
    int          got = 0;
    foreach (bs[i]) bs[i] = rnd_beat();
    for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
      ordy = !(c >= 2 && c <= 7);
      cur = mk(0, 0, 0);
      if (sent < 6) cur = bs[sent];
      step(sent < 6, cur, ordy);
      if (c <= 8) begin
        n_run++;
        if (in_ready0 !== !(c >= 3 && c <= 7)) begin
          n_fail++;
          $display("FAIL bp_in_ready c=%0d: got %b, expected %b",
                   c, in_ready0, !(c >= 3 && c <= 7));
        end
      end
      if (c == 3) held = out_y0;
      if (c > 3 && c <= 7) begin
        n_run++;
        if (out_valid0 !== 1'b1 || out_y0 !== held) begin
          n_fail++;
          $display("FAIL bp_stable c=%0d: got %h valid %b, expected %h valid 1",
                   c, out_y0, out_valid0, held);
        end
      end
      if (acc) sent++;
      if (drn) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got result %h, expected none", out_y0);
        end else begin
          e = q.pop_front();
          if (out_y0 !== e.y0 || out_y1 !== e.y1 || out_ovf0 !== e.ovf) begin
            n_fail++;
            $display("FAIL bp_y[%0d]: got %h/%h, expected %h/%h",
                     got, out_y0, out_y1, e.y0, e.y1);
          end
          got++;
        end
      end
    end
    n_run++;
    if (got != 6 || sent != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d sent %0d, expected 6 6", got, sent);
    end
  endtask

  task automatic test_full_rate();
    alm_log_t cur;
    exp_t     e;
    int       sent = 0;
    int       got = 0;
    cur = rnd_beat();
    for (int c = 0; c < 130 && (sent < 100 || q.size() > 0); c++) begin
      step(sent < 100, cur, 1);
      if (sent < 100) begin
        n_run++;
        if (!acc) begin
          n_fail++;
          $display("FAIL fr_accept c=%0d: got in_ready %b, expected 1", c, in_ready0);
        end
      end
      if (c >= 3 && c < 103) begin
        n_run++;
        if (!drn) begin
          n_fail++;
          $display("FAIL fr_gap c=%0d: got out_valid %b, expected 1", c, out_valid0);
        end
      end
      n_run++;
      if (in_ready1 !== in_ready0 || out_valid1 !== out_valid0) begin
        n_fail++;
        $display("FAIL fr_lockstep c=%0d: got %b%b, expected %b%b",
                 c, in_ready1, out_valid1, in_ready0, out_valid0);
      end
      if (acc) begin
        sent++;
        cur = rnd_beat();
      end
      if (drn && q.size() > 0) begin
        e = q.pop_front();
        n_run++;
        if (out_y0 !== e.y0 || out_y1 !== e.y1 ||
            out_ovf0 !== e.ovf || out_ovf1 !== e.ovf) begin
          n_fail++;
          $display("FAIL fr_y[%0d]: got %h/%h ovf %b, expected %h/%h ovf %b",
                   got, out_y0, out_y1, out_ovf0, e.y0, e.y1, e.ovf);
        end
        got++;
      end
    end
    n_run++;
    if (got != 100) begin
      n_fail++;
      $display("FAIL fr_count: got %0d results, expected 100", got);
    end
  endtask

  task automatic test_reset_flight();
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) step(1, rnd_beat(), 1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    n_run++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_y0 !== 32'd0) begin
      n_fail++;
      $display("FAIL rf_flush: got valid %b y %h, expected valid 0 y 0",
               out_valid0, out_y0);
    end
    for (int c = 0; c < 6; c++) begin
      step(0, mk(0, 0, 0), 1);
      n_run++;
      if (out_valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rf_stale c=%0d: got out_valid %b, expected 0", c, out_valid0);
      end
    end
    step(1, mk(20, 'h1234, 0), 1);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step(0, mk(0, 0, 0), 1);
      if (drn && q.size() > 0) begin
        lat = c;
        e = q.pop_front();
        n_run++;
        if (out_y0 !== e.y0 || out_y1 !== e.y1) begin
          n_fail++;
          $display("FAIL rf_y: got %h/%h, expected %h/%h",
                   out_y0, out_y1, e.y0, e.y1);
        end
      end
    end
    n_run++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL rf_latency: got %0d, expected 3", lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_round();
    test_backpressure();
    test_full_rate();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
